hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, mem-wait freeze and EX operand forwarding
// Optional stall-cycle counter port stall_cnt is built when HAZARD_STATS_EN is defined.
module hazard_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rw,
  input  logic       id_regwr,
  input  logic       id_memrd,
  input  logic       mem_wait,
  output logic       stall,
  output logic       bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] state
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MWAIT   = 2'b10
  } state_t;

  state_t curState;

  logic       exV, exRegwr, exMemrd;
  logic [4:0] exRs, exRt, exRw;
  logic       memV, memRegwr;
  logic [4:0] memRw;
  logic       wbV, wbRegwr;
  logic [4:0] wbRw;

  logic loadUse;
  logic memHit, wbHit;

  assign state = curState;

  always_comb begin
    loadUse = id_valid && exV && exMemrd && exRegwr && (exRw != 5'd0) &&
              ((exRw == id_rs) || (id_uses_rt && (exRw == id_rt)));
    stall   = 1'b0;
    bubble  = 1'b0;
    // reset forces the outputs low even while mem_wait is still high
    if (!reset) begin
      stall  = mem_wait || loadUse;
      bubble = !mem_wait && loadUse;
    end
  end

  assign memHit = memV && memRegwr && (memRw != 5'd0);
  assign wbHit  = wbV && wbRegwr && (wbRw != 5'd0);

  always_comb begin
    fwd_a = 2'b00;
    if (memHit && (memRw == exRs))
      fwd_a = 2'b01;
    else if (wbHit && (wbRw == exRs))
      fwd_a = 2'b10;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (memHit && (memRw == exRt))
      fwd_b = 2'b01;
    else if (wbHit && (wbRw == exRt))
      fwd_b = 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exV      <= 1'b0;
      exRs     <= 5'd0;
      exRt     <= 5'd0;
      exRw     <= 5'd0;
      exRegwr  <= 1'b0;
      exMemrd  <= 1'b0;
      memV     <= 1'b0;
      memRw    <= 5'd0;
      memRegwr <= 1'b0;
      wbV      <= 1'b0;
      wbRw     <= 5'd0;
      wbRegwr  <= 1'b0;
    end else if (!mem_wait) begin
      wbV      <= memV;
      wbRw     <= memRw;
      wbRegwr  <= memRegwr;
      memV     <= exV;
      memRw    <= exRw;
      memRegwr <= exRegwr;
      // a stalled ID instruction enters EX as a bubble and is reissued next cycle
      exV      <= id_valid && !stall;
      exRs     <= id_rs;
      exRt     <= id_rt;
      exRw     <= id_rw;
      exRegwr  <= id_regwr;
      exMemrd  <= id_memrd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      curState <= RUN;
    else if (mem_wait)
      curState <= MWAIT;
    else if (loadUse)
      curState <= LDSTALL;
    else
      curState <= RUN;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= 16'd0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit with a pipeline reference model
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rw = 5'd0;
  logic       id_uses_rt = 1'b0, id_regwr = 1'b0, id_memrd = 1'b0;
  logic       mem_wait = 1'b0;
  logic       stall, bubble;
  logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt;
`endif

  hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rw(id_rw), .id_regwr(id_regwr), .id_memrd(id_memrd),
    .mem_wait(mem_wait), .stall(stall), .bubble(bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt, rw;
    logic       usesRt, regwr, memrd;
  } instr_t;

  typedef struct packed {
    logic        stall, bubble;
    logic [1:0]  fa, fb, st;
    logic [15:0] cnt;
  } exp_t;

  exp_t   expQ[$];
  int     errors = 0;
  int     checks = 0;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t      pipe[3];
  instr_t      curId;
  logic        curReset = 1'b1, curMw = 1'b0, mStall = 1'b0;
  logic [1:0]  mState = 2'd0;
  logic [15:0] mCnt = 16'd0;

  function automatic logic hazardNow();
    return curId.v && pipe[0].v && pipe[0].memrd && pipe[0].regwr && pipe[0].rw != 0 &&
           (pipe[0].rw == curId.rs || (curId.usesRt && pipe[0].rw == curId.rt));
  endfunction

  function automatic logic [1:0] fwdFor(input logic [4:0] src);
    for (int k = 1; k <= 2; k++)
      if (pipe[k].v && pipe[k].regwr && pipe[k].rw != 0 && pipe[k].rw == src)
        return (k == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    mState = 2'd0;
    mCnt = 16'd0;
    mStall = 1'b0;
  endtask

  task automatic advanceModel();
    logic lu;
    if (curReset) begin
      clearModel();
    end else begin
      if (mStall && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      if (curMw) begin
        mState = 2'd2;
      end else begin
        lu = hazardNow();
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = curId;
        pipe[0].v = curId.v && !mStall;
        mState = lu ? 2'd1 : 2'd0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic mw, input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic ut, input logic [4:0] rw,
                      input logic rg, input logic mr);
    exp_t e;
    logic lu;
    @(posedge clk);
    advanceModel();
    #1;
    reset = rst; mem_wait = mw; id_valid = v; id_rs = rs; id_rt = rt;
    id_uses_rt = ut; id_rw = rw; id_regwr = rg; id_memrd = mr;
    curReset = rst; curMw = mw;
    curId = '{v: v, rs: rs, rt: rt, rw: rw, usesRt: ut, regwr: rg, memrd: mr};
    if (rst) clearModel();
    lu = hazardNow();
    e.stall  = !rst && (mw || lu);
    e.bubble = !rst && !mw && lu;
    e.fa     = fwdFor(pipe[0].rs);
    e.fb     = fwdFor(pipe[0].rt);
    e.st     = mState;
    e.cnt    = mCnt;
    mStall   = e.stall;
    expQ.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("stall", 16'(stall), 16'(e.stall));
        chk("bubble", 16'(bubble), 16'(e.bubble));
        chk("fwd_a", 16'(fwd_a), 16'(e.fa));
        chk("fwd_b", 16'(fwd_b), 16'(e.fb));
        chk("state", 16'(state), 16'(e.st));
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 5, 5, 1, 5, 1, 1);
    // scenario 1: lw $5 then add reading $5, add reissued after the stall
    step(0, 0, 1, 1, 2, 0, 5, 1, 1);
    step(0, 0, 1, 5, 7, 1, 6, 1, 0);
    step(0, 0, 1, 5, 7, 1, 6, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // scenario 2: add $3 then sub with rt=$3
    step(0, 0, 1, 1, 2, 1, 3, 1, 0);
    step(0, 0, 1, 8, 3, 1, 9, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // scenario 3: two writers of $4 then a reader
    step(0, 0, 1, 1, 2, 1, 4, 1, 0);
    step(0, 0, 1, 1, 2, 1, 4, 1, 0);
    step(0, 0, 1, 4, 2, 1, 10, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // scenario 4: lw $0 followed by a reader of $0
    step(0, 0, 1, 1, 2, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 1, 11, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // scenario 5: fresh counter, load-use hazard under a 3-cycle mem_wait
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 2, 0, 5, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 5, 7, 1, 6, 1, 0);
    step(0, 0, 1, 5, 7, 1, 6, 1, 0);
    step(0, 0, 1, 5, 7, 1, 6, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // scenario 6: reset asserted while in LDSTALL, with mem_wait also high
    step(0, 0, 1, 1, 2, 0, 5, 1, 1);
    step(0, 0, 1, 5, 7, 1, 6, 1, 0);
    step(1, 1, 1, 5, 7, 1, 6, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end
    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
